// File: rtl/xbar_scheduler_if.sv
// xbar_scheduler_if: request, crossbar-control and burst-tracking signals
// shared between the connection scheduler (master) and the requesters plus
// crossbar datapath (slave).
interface xbar_scheduler_if #(
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42
);
    localparam int DW = $clog2(N_OUTPUTS);

    logic [N_INPUTS-1:0]          req_val;
    logic [DW-1:0]                req_dest [N_INPUTS];
    logic [N_INPUTS-1:0]          grant;
    logic [CONTROL_BIT_WIDTH-1:0] control;
    logic                         control_val;
    logic                         control_rdy;
    logic                         xfer;
    logic                         xfer_last;
    logic                         busy;
    logic                         timeout_err;

    modport master (
        input  req_val, req_dest, control_rdy, xfer, xfer_last,
        output grant, control, control_val, busy, timeout_err
    );

    modport slave (
        output req_val, req_dest, control_rdy, xfer, xfer_last,
        input  grant, control, control_val, busy, timeout_err
    );
endinterface

// File: rtl/xbar_scheduler.sv
// xbar_scheduler: round-robin connection scheduler for a blocking crossbar.
// Picks one requester, sends its {input, output} control word over a
// val/rdy handshake, holds the grant for one burst of beats and then
// releases and re-arbitrates starting after the last winner.
// Optional idle-beat watchdog: define XBAR_SCHED_WATCHDOG_EN.
module xbar_scheduler #(
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42,
    parameter int BURST_LEN         = 4,
    parameter int TIMEOUT           = 16
) (
    input logic             clk,
    input logic             reset,
    xbar_scheduler_if.master bus
);
    localparam int IW  = $clog2(N_INPUTS);
    localparam int OW  = $clog2(N_OUTPUTS);
    localparam int CBW = CONTROL_BIT_WIDTH;
    localparam int BW  = $clog2(BURST_LEN + 1);

    // Elaboration-time sanity checks on the configuration
    if (N_INPUTS < 2)       begin : g_bad_inputs  $error("N_INPUTS must be >= 2");  end
    if (N_OUTPUTS < 2)      begin : g_bad_outputs $error("N_OUTPUTS must be >= 2"); end
    if (BURST_LEN < 1)      begin : g_bad_burst   $error("BURST_LEN must be >= 1"); end
    if (TIMEOUT < 1)        begin : g_bad_timeout $error("TIMEOUT must be >= 1");   end
    if (CBW < IW + OW)      begin : g_bad_cbw     $error("CONTROL_BIT_WIDTH too narrow"); end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          state_q,       state_d;
    logic [IW-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [IW-1:0]   winner_q,      winner_d;
    logic [BW-1:0]   beat_cnt_q,    beat_cnt_d;
    logic [N_INPUTS-1:0] grant_q,   grant_d;
    logic [CBW-1:0]  control_q,     control_d;

    logic [N_INPUTS-1:0] elig;
    logic            any_elig;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   scan_idx;
    int              scan_pos;
    logic [CBW-1:0]  ctrl_word;
    logic [IW-1:0]   next_ptr;
    logic            burst_done;
    logic            wd_fire;

`ifdef XBAR_SCHED_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   idle_cnt_q,    idle_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // A request is eligible only when its destination names a real output;
    // with a power-of-two output count every encodable destination is real.
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_elig
        if ((1 << OW) == N_OUTPUTS) begin : g_full
            assign elig[gi] = bus.req_val[gi];
        end else begin : g_masked
            assign elig[gi] = bus.req_val[gi] & (bus.req_dest[gi] < OW'(N_OUTPUTS));
        end
    end

    // Round-robin scan: first eligible requester at or after rr_ptr
    always_comb begin
        any_elig = 1'b0;
        pick     = '0;
        scan_pos = 0;
        scan_idx = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            scan_pos = int'(rr_ptr_q) + k;
            if (scan_pos >= N_INPUTS) begin
                scan_pos = scan_pos - N_INPUTS;
            end
            scan_idx = IW'(scan_pos);
            if (!any_elig && elig[scan_idx]) begin
                any_elig = 1'b1;
                pick     = scan_idx;
            end
        end
    end

    // Control word for the current pick: input select on top, output select below, zeros elsewhere
    always_comb begin
        ctrl_word                     = '0;
        ctrl_word[CBW-1 -: IW]        = pick;
        ctrl_word[CBW-IW-1 -: OW]     = bus.req_dest[pick];
    end

    // Pointer value after the current winner, wrapping at N_INPUTS
    always_comb begin
        next_ptr = winner_q + IW'(1);
        if (int'(winner_q) == N_INPUTS - 1) begin
            next_ptr = '0;
        end
    end

    // Next-state and output-register logic for IDLE -> CONFIG -> ACTIVE -> IDLE
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        winner_d   = winner_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        control_d  = control_q;
        burst_done = 1'b0;
        wd_fire    = 1'b0;
`ifdef XBAR_SCHED_WATCHDOG_EN
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d   = CONFIG;
                    winner_d  = pick;
                    control_d = ctrl_word;
                end
            end
            CONFIG: begin
                // control_val is high throughout CONFIG, so rdy completes the handshake
                if (bus.control_rdy) begin
                    state_d           = ACTIVE;
                    grant_d           = '0;
                    grant_d[winner_q] = 1'b1;
                    beat_cnt_d        = '0;
`ifdef XBAR_SCHED_WATCHDOG_EN
                    idle_cnt_d        = '0;
`endif
                end
            end
            ACTIVE: begin
                if (bus.xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                burst_done = bus.xfer &&
                             (bus.xfer_last || (beat_cnt_q == BW'(BURST_LEN - 1)));
`ifdef XBAR_SCHED_WATCHDOG_EN
                idle_cnt_d = bus.xfer ? '0 : idle_cnt_q + TW'(1);
                wd_fire    = !bus.xfer && (idle_cnt_q == TW'(TIMEOUT - 1));
                timeout_err_d = wd_fire && !burst_done;
`endif
                if (burst_done || wd_fire) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            control_q  <= '0;
`ifdef XBAR_SCHED_WATCHDOG_EN
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            control_q  <= control_d;
`ifdef XBAR_SCHED_WATCHDOG_EN
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.control     = control_q;
    assign bus.control_val = (state_q == CONFIG);
    assign bus.busy        = (state_q != IDLE);
`ifdef XBAR_SCHED_WATCHDOG_EN
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_scheduler.sv
// tb_xbar_scheduler: randomized and directed connection rounds for
// xbar_scheduler, checked cycle by cycle against a transaction-level model
// (round-robin pointer, beat count, idle count) kept in the bench.
module tb_xbar_scheduler;
    localparam int NI    = 2;
    localparam int NO    = 2;
    localparam int CBW   = 42;
    localparam int BURST = 4;
    localparam int TMO   = 16;
    localparam int IW    = $clog2(NI);
    localparam int OW    = $clog2(NO);
    localparam int DW    = $clog2(NO);

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;
    int model_rr;

    xbar_scheduler_if #(.N_INPUTS(NI), .N_OUTPUTS(NO), .CONTROL_BIT_WIDTH(CBW)) bus ();

    xbar_scheduler #(
        .N_INPUTS(NI), .N_OUTPUTS(NO), .CONTROL_BIT_WIDTH(CBW),
        .BURST_LEN(BURST), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_grant"}, 64'(bus.grant), 64'd0);
        check_eq({tag, "_cval"},  64'(bus.control_val), 64'd0);
        check_eq({tag, "_busy"},  64'(bus.busy), 64'd0);
    endtask

    // One connection round. dsel<0 randomizes destinations; last_mode -1 never
    // raises xfer_last, 0 raises it randomly, k>0 raises it on beat k;
    // rst_after>=0 pulses reset once that many beats have been accepted.
    task automatic run_round(input logic [NI-1:0] mask, input int dsel, input int stall,
                             input int last_mode, input int rst_after, input int xfer_pct);
        int dst [NI];
        int win;
        int p;
        int beats;
        int idle;
        bit x;
        bit l;
        bit rel;
        bit wd;
        logic [63:0] exp_ctrl;
        logic [NI-1:0] exp_grant;

        for (int i = 0; i < NI; i++) begin
            dst[i] = (dsel >= 0) ? dsel : int'($urandom_range(0, (1 << DW) - 1));
            bus.req_dest[i] = DW'(dst[i]);
        end
        bus.req_val     = mask;
        bus.control_rdy = (stall == 0);
        bus.xfer        = 1'b0;
        bus.xfer_last   = 1'b0;

        win = -1;
        for (int k = 0; k < NI; k++) begin
            p = (model_rr + k) % NI;
            if (win < 0 && mask[p] && dst[p] < NO) win = p;
        end

        @(negedge clk);
        if (win < 0) begin
            check_idle_outputs("noreq");
            bus.req_val = '0;
            return;
        end

        exp_ctrl = (64'(win) << (CBW - IW)) | (64'(dst[win]) << (CBW - IW - OW));
        check_eq("cfg_val",   64'(bus.control_val), 64'd1);
        check_eq("cfg_word",  64'(bus.control), exp_ctrl);
        check_eq("cfg_grant", 64'(bus.grant), 64'd0);
        check_eq("cfg_busy",  64'(bus.busy), 64'd1);

        if (stall > 0) begin
            for (int s = 1; s < stall; s++) begin
                @(negedge clk);
                check_eq("stall_val",   64'(bus.control_val), 64'd1);
                check_eq("stall_word",  64'(bus.control), exp_ctrl);
                check_eq("stall_grant", 64'(bus.grant), 64'd0);
            end
            bus.control_rdy = 1'b1;
        end

        @(negedge clk);
        bus.control_rdy = 1'b0;
        exp_grant = '0;
        exp_grant[win] = 1'b1;
        check_eq("hs_grant", 64'(bus.grant), 64'(exp_grant));
        check_eq("hs_cval",  64'(bus.control_val), 64'd0);
        check_eq("hs_word",  64'(bus.control), exp_ctrl);
        check_eq("hs_busy",  64'(bus.busy), 64'd1);

        // Requests are ignored while the connection is held
        bus.req_val = NI'($urandom);
        for (int i = 0; i < NI; i++) bus.req_dest[i] = DW'($urandom);

        beats = 0;
        idle  = 0;
        for (int c = 0; c < 2000; c++) begin
            if (rst_after >= 0 && beats == rst_after) begin
                reset = 1'b1;
                bus.xfer = 1'b0;
                bus.xfer_last = 1'b0;
                @(negedge clk);
                check_idle_outputs("rst");
                check_eq("rst_word", 64'(bus.control), 64'd0);
                check_eq("rst_terr", 64'(bus.timeout_err), 64'd0);
                reset = 1'b0;
                model_rr = 0;
                bus.req_val = '0;
                return;
            end
            x = ($urandom_range(0, 99) < xfer_pct);
            if (last_mode > 0)       l = (beats + 1 == last_mode);
            else if (last_mode == 0) l = ($urandom_range(0, 3) == 0);
            else                     l = 1'b0;
            bus.xfer      = x;
            bus.xfer_last = l;
            if (x) beats++;
            idle = x ? 0 : idle + 1;
            rel = x && (l || beats == BURST);
            wd  = 1'b0;
`ifdef XBAR_SCHED_WATCHDOG_EN
            if (!x && idle == TMO) begin
                rel = 1'b1;
                wd  = 1'b1;
            end
`endif
            @(negedge clk);
            check_eq("act_grant", 64'(bus.grant), rel ? 64'd0 : 64'(exp_grant));
            check_eq("act_busy",  64'(bus.busy), rel ? 64'd0 : 64'd1);
            check_eq("act_cval",  64'(bus.control_val), 64'd0);
            check_eq("act_terr",  64'(bus.timeout_err), 64'(wd));
            if (rel) begin
                model_rr = (win + 1) % NI;
                bus.xfer = 1'b0;
                bus.xfer_last = 1'b0;
                bus.req_val = '0;
                return;
            end
        end
        check_eq("burst_never_released", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_rr = 0;
        reset    = 1'b1;
        bus.req_val     = '0;
        for (int i = 0; i < NI; i++) bus.req_dest[i] = '0;
        bus.control_rdy = 1'b0;
        bus.xfer        = 1'b0;
        bus.xfer_last   = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_word", 64'(bus.control), 64'd0);
        check_eq("reset_terr", 64'(bus.timeout_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Input 0 to output 1 with rdy already high
        run_round(2'b01, 1, 0, -1, -1, 100);
        // Both requesting, full 4-beat bursts: grants alternate
        repeat (4) run_round(2'b11, -1, 0, -1, -1, 100);
        // Early xfer_last on beat 2
        run_round(2'b11, -1, 0, 2, -1, 100);
        // xfer_last on beat 1
        run_round(2'b11, -1, 0, 1, -1, 70);
        // Five cycles of control_rdy low in CONFIG
        run_round(2'b01, 0, 5, -1, -1, 100);
        // Make input 1 the next candidate, then reset mid-burst after 2 beats
        run_round(2'b01, 1, 0, -1, -1, 100);
        run_round(2'b11, -1, 0, -1, 2, 100);
        // After reset the pointer is back at input 0
        run_round(2'b11, -1, 0, -1, -1, 80);
        run_round(2'b10, -1, 1, -1, -1, 80);
`ifdef XBAR_SCHED_WATCHDOG_EN
        // No beats at all: watchdog release, then the other requester wins
        run_round(2'b11, -1, 0, -1, -1, 0);
        run_round(2'b11, -1, 0, -1, -1, 100);
`endif
        // Randomized rounds
        for (int r = 0; r < 60; r++) begin
            run_round(NI'($urandom_range(0, (1 << NI) - 1)), -1,
                      int'($urandom_range(0, 3)), 0, -1,
                      int'($urandom_range(30, 100)));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                check_idle_outputs("gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
